fir_coefficient_scheduler: RTL and testbench
============================================

FIR_COEFFICIENT_SCHEDULER -- requirements
Module: fir_coefficient_scheduler

Interface
REQ-001 SHALL have parameter NUMBER_TAPS, default 16: filter taps, i.e. coefficients per bank.
REQ-002 SHALL have parameter COEFFICIENT_WIDTH, default 16: coefficient word width.
REQ-003 SHALL have parameter DATA_WIDTH, default 16: width of the gated sample stream.
REQ-004 SHALL have parameter NUMBER_BANKS, default 4: number of stored coefficient banks; BB = clog2(NUMBER_BANKS), TB = clog2(NUMBER_TAPS).
REQ-005 SHALL have port clock, in, 1: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, in, 1: synchronous, active-high reset.
REQ-007 SHALL have ports cfg_wr_en (in, 1), cfg_wr_bank (in, BB), cfg_wr_index (in, TB), cfg_wr_data (in, COEFFICIENT_WIDTH): coefficient memory write port.
REQ-008 SHALL have port cfg_wr_error, out, 1: one-cycle pulse when a write is rejected.
REQ-009 SHALL have ports bank_req_valid (in, 1), bank_req (in, BB), bank_req_ready (out, 1): bank-switch request handshake.
REQ-010 SHALL have ports active_bank (out, BB), coefficients_loaded (out, 1) and busy (out, 1).
REQ-011 SHALL have ports up_tvalid (in, 1), up_tready (out, 1), up_tdata (in, DATA_WIDTH), up_tlast (in, 1): upstream sample stream.
REQ-012 SHALL have ports filt_tvalid (out, 1), filt_tready (in, 1), filt_tdata (out, DATA_WIDTH), filt_tlast (out, 1): stream to the filter data input.
REQ-013 SHALL have port samples_remaining, in, 1: high while the filter delay line holds samples.
REQ-014 SHALL have ports coeff_aresetn (out, 1), coeff_tdata (out, COEFFICIENT_WIDTH), coeff_tvalid (out, 1), coeff_tlast (out, 1), coeff_tready (in, 1): filter coefficient interface.

Function
REQ-015 SHALL hold NUMBER_BANKS x NUMBER_TAPS coefficients; a write stores cfg_wr_data at [cfg_wr_bank][cfg_wr_index] on the same edge.
REQ-016 SHALL reject a write to the bank being loaded while busy=1 (memory unchanged) and pulse cfg_wr_error on the next cycle; writes to any other bank are always accepted.
REQ-017 SHALL track in_frame: set on an accepted upstream beat with up_tlast=0; cleared on an accepted beat with up_tlast=1.
REQ-018 SHALL implement states IDLE, DRAIN, CLEAR, PRIME and LOAD.
REQ-019 SHALL drive bank_req_ready=1 only in IDLE with in_frame=0; a handshake latches bank_req and moves to DRAIN.
REQ-020 SHALL pass the stream combinationally only when state=IDLE and coefficients_loaded=1: filt_tvalid=up_tvalid, up_tready=filt_tready, data and last passed through; otherwise filt_tvalid=0 and up_tready=0.
REQ-021 SHALL leave DRAIN for CLEAR on the first cycle in which samples_remaining=0.
REQ-022 SHALL hold CLEAR for exactly one cycle with coeff_aresetn=0; coeff_aresetn SHALL be 1 in every other state.
REQ-023 SHALL, in PRIME (one cycle), register tap 0 of the latched bank into coeff_tdata.
REQ-024 SHALL, in LOAD, hold coeff_tvalid=1; on each coeff_tvalid and coeff_tready handshake the tap index advances and coeff_tdata updates to the next tap on the following edge; with coeff_tready=0, tdata and index hold.
REQ-025 SHALL assert coeff_tlast=1 exactly while tap NUMBER_TAPS-1 is presented.
REQ-026 SHALL, on the tlast handshake, return to IDLE and set active_bank to the latched bank and coefficients_loaded to 1 on that edge.
REQ-027 SHALL deliver coefficients in ascending tap order, each exactly once per load.
REQ-028 SHALL drive busy=1 in every state except IDLE.
REQ-029 SHALL treat a request for the bank already active as a full reload.

Reset
REQ-030 SHALL, on reset, set state=IDLE, active_bank=0, coefficients_loaded=0, in_frame=0, coeff_tvalid=0, coeff_tlast=0, coeff_tdata=0, coeff_aresetn=1, cfg_wr_error=0 and tap index=0.
REQ-031 SHALL NOT clear coefficient memory on reset.
REQ-032 SHALL, when reset is asserted mid-LOAD, abort immediately and leave coefficients_loaded=0.

Configuration
REQ-033 SHALL, with FIR_SCHED_STATS_EN defined, add output reload_count (16 bits, reset 0), incremented by 1 per completed load and wrapping at 0xFFFF to 0.
REQ-034 SHALL, without FIR_SCHED_STATS_EN, omit the reload_count port and its logic, with all other behaviour identical.

Verification
REQ-035 SHALL cover: reset, then bank 1 taps written as 1..16, then request bank 1 with samples_remaining=0 -> coeff_aresetn low for 1 cycle, 1 PRIME cycle, then 16 beats with values 1..16 and tlast on the 16th; active_bank=1 and coefficients_loaded=1.
REQ-036 SHALL cover: coeff_tready toggled 1,0,1,0 during LOAD -> no tap skipped or repeated; load completes after 16 handshakes.
REQ-037 SHALL cover: request raised mid-frame (3 of 8 beats sent) -> bank_req_ready=0 until the tlast beat is accepted, then the handshake occurs.
REQ-038 SHALL cover: samples_remaining held high 20 cycles after a request -> DRAIN lasts 20 cycles and up_tready=0 throughout.
REQ-039 SHALL cover: a write to the loading bank during LOAD -> cfg_wr_error pulses once and memory is unchanged; a write to another bank in the same window succeeds.
REQ-040 SHALL cover: reset asserted at load beat 7 -> state IDLE, coeff_tvalid=0 and coefficients_loaded=0 on the next cycle; with FIR_SCHED_STATS_EN defined, reload_count is 0.

Source files
------------

// File: rtl/fir_coefficient_scheduler.sv
// Coefficient bank store and reload sequencer for a streaming FIR filter.
// Optional build macro FIR_SCHED_STATS_EN adds a 16-bit completed-load counter.
module fir_coefficient_scheduler #(
    parameter int NUMBER_TAPS       = 16,
    parameter int COEFFICIENT_WIDTH = 16,
    parameter int DATA_WIDTH        = 16,
    parameter int NUMBER_BANKS      = 4,
    localparam int BB = $clog2(NUMBER_BANKS),
    localparam int TB = $clog2(NUMBER_TAPS)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_wr_en,
    input  logic [BB-1:0]                cfg_wr_bank,
    input  logic [TB-1:0]                cfg_wr_index,
    input  logic [COEFFICIENT_WIDTH-1:0] cfg_wr_data,
    output logic                         cfg_wr_error,
    input  logic                         bank_req_valid,
    input  logic [BB-1:0]                bank_req,
    output logic                         bank_req_ready,
    output logic [BB-1:0]                active_bank,
    output logic                         coefficients_loaded,
    output logic                         busy,
    input  logic                         up_tvalid,
    output logic                         up_tready,
    input  logic [DATA_WIDTH-1:0]        up_tdata,
    input  logic                         up_tlast,
    output logic                         filt_tvalid,
    input  logic                         filt_tready,
    output logic [DATA_WIDTH-1:0]        filt_tdata,
    output logic                         filt_tlast,
    input  logic                         samples_remaining,
    output logic                         coeff_aresetn,
    output logic [COEFFICIENT_WIDTH-1:0] coeff_tdata,
    output logic                         coeff_tvalid,
    output logic                         coeff_tlast,
`ifdef FIR_SCHED_STATS_EN
    output logic [15:0]                  reload_count,
`endif
    input  logic                         coeff_tready
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_CLEAR = 3'd2,
        S_PRIME = 3'd3,
        S_LOAD  = 3'd4
    } state_t;

    localparam logic [TB-1:0] LAST_TAP = TB'(NUMBER_TAPS - 1);

    logic [COEFFICIENT_WIDTH-1:0] r_mem [NUMBER_BANKS][NUMBER_TAPS];

    state_t                       r_state;
    logic [BB-1:0]                r_bank;
    logic [BB-1:0]                r_active_bank;
    logic                         r_loaded;
    logic                         r_in_frame;
    logic                         r_coeff_tvalid;
    logic                         r_coeff_tlast;
    logic [COEFFICIENT_WIDTH-1:0] r_coeff_tdata;
    logic                         r_coeff_aresetn;
    logic                         r_wr_error;
    logic [TB-1:0]                r_idx;

    logic          w_busy;
    logic          w_pass;
    logic          w_up_accept;
    logic          w_req_hs;
    logic          w_wr_reject;
    logic          w_coeff_hs;
    logic          w_load_done;
    logic [TB-1:0] w_idx_next;

    assign w_busy      = (r_state != S_IDLE);
    assign w_pass      = (r_state == S_IDLE) && r_loaded;
    assign w_up_accept = up_tvalid && up_tready;
    assign w_req_hs    = bank_req_valid && bank_req_ready;
    // The bank latched for a reload is locked against writes until the load finishes.
    assign w_wr_reject = cfg_wr_en && w_busy && (cfg_wr_bank == r_bank);
    assign w_coeff_hs  = (r_state == S_LOAD) && r_coeff_tvalid && coeff_tready;
    assign w_load_done = w_coeff_hs && r_coeff_tlast;
    assign w_idx_next  = r_idx + TB'(1'b1);

    // Stream gate: samples only reach the filter once a full bank is loaded and idle.
    always_comb begin
        filt_tvalid = 1'b0;
        up_tready   = 1'b0;
        if (w_pass) begin
            filt_tvalid = up_tvalid;
            up_tready   = filt_tready;
        end else begin
            filt_tvalid = 1'b0;
            up_tready   = 1'b0;
        end
    end

    assign filt_tdata          = up_tdata;
    assign filt_tlast          = up_tlast;
    assign bank_req_ready      = (r_state == S_IDLE) && !r_in_frame;
    assign busy                = w_busy;
    assign active_bank         = r_active_bank;
    assign coefficients_loaded = r_loaded;
    assign coeff_aresetn       = r_coeff_aresetn;
    assign coeff_tdata         = r_coeff_tdata;
    assign coeff_tvalid        = r_coeff_tvalid;
    assign coeff_tlast         = r_coeff_tlast;
    assign cfg_wr_error        = r_wr_error;

    // Coefficient storage write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (cfg_wr_en && !w_wr_reject) begin
            r_mem[cfg_wr_bank][cfg_wr_index] <= cfg_wr_data;
        end
    end

    // Reload sequencer, frame tracker and registered interface outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_bank          <= {BB{1'b0}};
            r_active_bank   <= {BB{1'b0}};
            r_loaded        <= 1'b0;
            r_in_frame      <= 1'b0;
            r_coeff_tvalid  <= 1'b0;
            r_coeff_tlast   <= 1'b0;
            r_coeff_tdata   <= {COEFFICIENT_WIDTH{1'b0}};
            r_coeff_aresetn <= 1'b1;
            r_wr_error      <= 1'b0;
            r_idx           <= {TB{1'b0}};
        end else begin
            r_wr_error <= w_wr_reject;
            if (w_up_accept) begin
                r_in_frame <= !up_tlast;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req_hs) begin
                        r_bank  <= bank_req;
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!samples_remaining) begin
                        r_coeff_aresetn <= 1'b0;
                        r_state         <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    r_coeff_aresetn <= 1'b1;
                    r_state         <= S_PRIME;
                end
                S_PRIME: begin
                    r_idx          <= {TB{1'b0}};
                    r_coeff_tdata  <= r_mem[r_bank][{TB{1'b0}}];
                    r_coeff_tvalid <= 1'b1;
                    r_coeff_tlast  <= (LAST_TAP == {TB{1'b0}});
                    r_state        <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_load_done) begin
                        r_coeff_tvalid <= 1'b0;
                        r_coeff_tlast  <= 1'b0;
                        r_active_bank  <= r_bank;
                        r_loaded       <= 1'b1;
                        r_state        <= S_IDLE;
                    end else if (w_coeff_hs) begin
                        r_idx         <= w_idx_next;
                        r_coeff_tdata <= r_mem[r_bank][w_idx_next];
                        r_coeff_tlast <= (w_idx_next == LAST_TAP);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef FIR_SCHED_STATS_EN
    logic [15:0] r_reload_count;

    // Completed-load counter; wraps naturally at 16 bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_reload_count <= 16'd0;
        end else if (w_load_done) begin
            r_reload_count <= r_reload_count + 16'd1;
        end
    end

    assign reload_count = r_reload_count;
`else
    // No load statistics in this build.
`endif

endmodule

// File: tb/tb_fir_coefficient_scheduler.sv
// Self-checking bench for fir_coefficient_scheduler: a bank/tap array model predicts
// each reload's beat sequence, stream gating, frame tracking and write rejection.
module tb_fir_coefficient_scheduler;
    localparam int NT = 16;
    localparam int CW = 16;
    localparam int DW = 16;
    localparam int NB = 4;
    localparam int BB = 2;
    localparam int TW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cfg_wr_en = 1'b0;
    logic [BB-1:0] cfg_wr_bank = '0;
    logic [TW-1:0] cfg_wr_index = '0;
    logic [CW-1:0] cfg_wr_data = '0;
    logic          cfg_wr_error;
    logic          bank_req_valid = 1'b0;
    logic [BB-1:0] bank_req = '0;
    logic          bank_req_ready;
    logic [BB-1:0] active_bank;
    logic          coefficients_loaded;
    logic          busy;
    logic          up_tvalid = 1'b0;
    logic          up_tready;
    logic [DW-1:0] up_tdata = '0;
    logic          up_tlast = 1'b0;
    logic          filt_tvalid;
    logic          filt_tready = 1'b0;
    logic [DW-1:0] filt_tdata;
    logic          filt_tlast;
    logic          samples_remaining = 1'b0;
    logic          coeff_aresetn;
    logic [CW-1:0] coeff_tdata;
    logic          coeff_tvalid;
    logic          coeff_tlast;
    logic          coeff_tready = 1'b0;
`ifdef FIR_SCHED_STATS_EN
    logic [15:0]   reload_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [CW-1:0] model_mem [NB][NT];
    int m_active = 0;
    bit m_loaded = 1'b0;
    bit m_in_frame = 1'b0;
    int m_reloads = 0;

    fir_coefficient_scheduler dut (
        .clock(clock), .reset(reset),
        .cfg_wr_en(cfg_wr_en), .cfg_wr_bank(cfg_wr_bank), .cfg_wr_index(cfg_wr_index),
        .cfg_wr_data(cfg_wr_data), .cfg_wr_error(cfg_wr_error),
        .bank_req_valid(bank_req_valid), .bank_req(bank_req), .bank_req_ready(bank_req_ready),
        .active_bank(active_bank), .coefficients_loaded(coefficients_loaded), .busy(busy),
        .up_tvalid(up_tvalid), .up_tready(up_tready), .up_tdata(up_tdata), .up_tlast(up_tlast),
        .filt_tvalid(filt_tvalid), .filt_tready(filt_tready), .filt_tdata(filt_tdata),
        .filt_tlast(filt_tlast), .samples_remaining(samples_remaining),
        .coeff_aresetn(coeff_aresetn), .coeff_tdata(coeff_tdata), .coeff_tvalid(coeff_tvalid),
        .coeff_tlast(coeff_tlast),
`ifdef FIR_SCHED_STATS_EN
        .reload_count(reload_count),
`endif
        .coeff_tready(coeff_tready)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic write_coef(input int bank, input int idx, input logic [CW-1:0] data);
        cfg_wr_en    = 1'b1;
        cfg_wr_bank  = BB'(bank);
        cfg_wr_index = TW'(idx);
        cfg_wr_data  = data;
        tick();
        cfg_wr_en = 1'b0;
        model_mem[bank][idx] = data;
        #1;
        checks++;
        if (cfg_wr_error !== 1'b0) begin
            failures++;
            $display("FAIL wr_error_idle got=%0b exp=0", cfg_wr_error);
        end
    endtask

    // Full reload of one bank. ready_mode: 0 always ready, 1 toggling, 2 random.
    // Samples stay high for drain_high cycles counting from the request cycle.
    task automatic run_load(input int bank, input int ready_mode, input int drain_high,
                            input bit wr_test, input int abort_beat);
        logic [CW-1:0] exp_q[$];
        int k;
        int cyc;
        int drain_cycles;
        int exp_drain;
        int other;
        bit bad_drain;
        bit done;
        bit aborted;
        for (int i = 0; i < NT; i++) exp_q.push_back(model_mem[bank][i]);
        other = (bank + 1) % NB;

        up_tvalid = 1'b0;
        bank_req = BB'(bank);
        bank_req_valid = 1'b1;
        samples_remaining = (drain_high > 0);
        #1;
        checks++;
        if (bank_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL req_ready got=%0b exp=1", bank_req_ready);
        end
        tick();
        bank_req_valid = 1'b0;
        up_tvalid = 1'b1;
        filt_tready = 1'b1;
        up_tlast = 1'b0;

        drain_cycles = 0;
        bad_drain = 1'b0;
        while (coeff_aresetn === 1'b1 && drain_cycles < 100) begin
            if (drain_cycles + 1 >= drain_high) samples_remaining = 1'b0;
            #1;
            if (up_tready !== 1'b0 || busy !== 1'b1 || filt_tvalid !== 1'b0) bad_drain = 1'b1;
            drain_cycles++;
            tick();
        end
        exp_drain = (drain_high == 0) ? 1 : drain_high;
        checks++;
        if (drain_cycles != exp_drain) begin
            failures++;
            $display("FAIL drain_len got=%0d exp=%0d", drain_cycles, exp_drain);
        end
        checks++;
        if (bad_drain) begin
            failures++;
            $display("FAIL drain_gate got=stream_open_or_idle exp=blocked_and_busy");
        end

        up_tvalid = 1'b0;
        samples_remaining = 1'b0;
        #1;
        checks++;
        if (coeff_aresetn !== 1'b0 || coeff_tvalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL clear_cycle got aresetn=%0b tvalid=%0b busy=%0b exp 0 0 1",
                     coeff_aresetn, coeff_tvalid, busy);
        end
        tick();
        checks++;
        if (coeff_aresetn !== 1'b1 || coeff_tvalid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL prime_cycle got aresetn=%0b tvalid=%0b busy=%0b exp 1 0 1",
                     coeff_aresetn, coeff_tvalid, busy);
        end
        tick();

        k = 0;
        cyc = 0;
        done = 1'b0;
        aborted = 1'b0;
        while (!done && cyc < 200) begin
            case (ready_mode)
                0: coeff_tready = 1'b1;
                1: coeff_tready = (cyc % 2 == 0);
                default: coeff_tready = 1'($urandom_range(0, 1));
            endcase
            cfg_wr_en = 1'b0;
            if (wr_test && cyc == 2) begin
                cfg_wr_en = 1'b1;
                cfg_wr_bank = BB'(bank);
                cfg_wr_index = TW'(5);
                cfg_wr_data = ~model_mem[bank][5];
            end else if (wr_test && cyc == 3) begin
                cfg_wr_en = 1'b1;
                cfg_wr_bank = BB'(other);
                cfg_wr_index = TW'(3);
                cfg_wr_data = CW'($urandom);
                model_mem[other][3] = cfg_wr_data;
            end
            if (k == abort_beat) reset = 1'b1;
            #1;
            if (wr_test && (cyc == 3 || cyc == 4)) begin
                checks++;
                if (cfg_wr_error !== (cyc == 3)) begin
                    failures++;
                    $display("FAIL wr_error_load cyc=%0d got=%0b exp=%0b", cyc, cfg_wr_error, cyc == 3);
                end
            end
            if (reset) begin
                tick();
                reset = 1'b0;
                coeff_tready = 1'b0;
                cfg_wr_en = 1'b0;
                m_loaded = 1'b0;
                m_active = 0;
                m_in_frame = 1'b0;
                m_reloads = 0;
                #1;
                checks++;
                if (busy !== 1'b0 || coeff_tvalid !== 1'b0 || coefficients_loaded !== 1'b0 ||
                    active_bank !== 2'd0 || coeff_aresetn !== 1'b1) begin
                    failures++;
                    $display("FAIL abort got busy=%0b tvalid=%0b loaded=%0b bank=%0d aresetn=%0b exp 0 0 0 0 1",
                             busy, coeff_tvalid, coefficients_loaded, active_bank, coeff_aresetn);
                end
`ifdef FIR_SCHED_STATS_EN
                checks++;
                if (reload_count !== 16'd0) begin
                    failures++;
                    $display("FAIL abort_count got=%0d exp=0", reload_count);
                end
`endif
                aborted = 1'b1;
                done = 1'b1;
            end else begin
                checks++;
                if (coeff_tvalid !== 1'b1 || coeff_tdata !== exp_q[k] || coeff_tlast !== (k == NT - 1)) begin
                    failures++;
                    $display("FAIL load_beat k=%0d got valid=%0b data=%h last=%0b exp 1 %h %0b",
                             k, coeff_tvalid, coeff_tdata, coeff_tlast, exp_q[k], k == NT - 1);
                end
                if (coeff_tready) k++;
                tick();
                if (k == NT) done = 1'b1;
            end
            cyc++;
        end
        cfg_wr_en = 1'b0;
        coeff_tready = 1'b0;
        if (!done) begin
            failures++;
            checks++;
            $display("FAIL load_timeout got beats=%0d exp=%0d", k, NT);
        end else if (!aborted) begin
            m_active = bank;
            m_loaded = 1'b1;
            m_reloads++;
            #1;
            checks++;
            if (busy !== 1'b0 || active_bank !== BB'(m_active) || coefficients_loaded !== 1'b1 ||
                coeff_tvalid !== 1'b0) begin
                failures++;
                $display("FAIL load_done got busy=%0b bank=%0d loaded=%0b tvalid=%0b exp 0 %0d 1 0",
                         busy, active_bank, coefficients_loaded, coeff_tvalid, m_active);
            end
`ifdef FIR_SCHED_STATS_EN
            checks++;
            if (reload_count !== 16'(m_reloads)) begin
                failures++;
                $display("FAIL reload_count got=%0d exp=%0d", reload_count, m_reloads);
            end
`endif
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        up_tvalid = 1'b1;
        filt_tready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || active_bank !== 2'd0 || coefficients_loaded !== 1'b0 ||
            coeff_aresetn !== 1'b1 || coeff_tvalid !== 1'b0 || coeff_tlast !== 1'b0 ||
            coeff_tdata !== 16'd0 || cfg_wr_error !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got busy=%0b bank=%0d loaded=%0b aresetn=%0b tv=%0b tl=%0b td=%h err=%0b",
                     busy, active_bank, coefficients_loaded, coeff_aresetn, coeff_tvalid,
                     coeff_tlast, coeff_tdata, cfg_wr_error);
        end
        checks++;
        if (filt_tvalid !== 1'b0 || up_tready !== 1'b0 || bank_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_stream got fv=%0b ur=%0b brr=%0b exp 0 0 1",
                     filt_tvalid, up_tready, bank_req_ready);
        end
        reset = 1'b0;
        up_tvalid = 1'b0;
        filt_tready = 1'b0;
        tick();
    endtask

    task automatic test_first_load();
        for (int b = 0; b < NB; b++) begin
            for (int t = 0; t < NT; t++) begin
                write_coef(b, t, (b == 1) ? CW'(t + 1) : CW'($urandom));
            end
        end
        run_load(1, 0, 0, 1'b0, -1);
    endtask

    task automatic test_passthrough();
        bit bad_stream;
        bit bad_ready;
        bad_stream = 1'b0;
        bad_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
            up_tvalid = 1'($urandom_range(0, 1));
            filt_tready = 1'($urandom_range(0, 1));
            up_tdata = DW'($urandom);
            up_tlast = ($urandom_range(0, 3) == 0);
            #1;
            if (filt_tvalid !== up_tvalid || up_tready !== filt_tready ||
                filt_tdata !== up_tdata || filt_tlast !== up_tlast) bad_stream = 1'b1;
            if (bank_req_ready !== !m_in_frame) bad_ready = 1'b1;
            if (up_tvalid && filt_tready) m_in_frame = !up_tlast;
            tick();
        end
        checks++;
        if (bad_stream) begin
            failures++;
            $display("FAIL passthrough got=mismatched_stream exp=identical_stream");
        end
        checks++;
        if (bad_ready) begin
            failures++;
            $display("FAIL frame_ready got=wrong_bank_req_ready exp=not_in_frame");
        end
        up_tvalid = 1'b1;
        filt_tready = 1'b1;
        up_tlast = 1'b1;
        tick();
        m_in_frame = 1'b0;
        up_tvalid = 1'b0;
        up_tlast = 1'b0;
    endtask

    task automatic test_ready_toggle();
        for (int t = 0; t < NT; t++) write_coef(2, t, CW'($urandom));
        run_load(2, 1, 0, 1'b0, -1);
    endtask

    task automatic test_midframe();
        bit bad;
        bad = 1'b0;
        up_tvalid = 1'b1;
        filt_tready = 1'b1;
        up_tlast = 1'b0;
        for (int b = 1; b <= 3; b++) begin
            up_tdata = DW'(b);
            tick();
        end
        bank_req = 2'd3;
        bank_req_valid = 1'b1;
        for (int b = 4; b <= 8; b++) begin
            up_tdata = DW'(b);
            up_tlast = (b == 8);
            #1;
            if (bank_req_ready !== 1'b0 || busy !== 1'b0) bad = 1'b1;
            tick();
        end
        up_tvalid = 1'b0;
        up_tlast = 1'b0;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL midframe_hold got=ready_or_busy_in_frame exp=ready_low_idle");
        end
        run_load(3, 2, 0, 1'b0, -1);
    endtask

    task automatic test_drain();
        run_load(0, 0, 20, 1'b0, -1);
    endtask

    task automatic test_write_during_load();
        run_load(1, 1, 0, 1'b1, -1);
        run_load(2, 0, 0, 1'b0, -1);
        run_load(1, 2, 3, 1'b0, -1);
    endtask

    task automatic test_abort();
        run_load(0, 0, 0, 1'b0, 7);
        tick();
        run_load(0, 2, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_passthrough();
        test_ready_toggle();
        test_midframe();
        test_drain();
        test_write_during_load();
        test_abort();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "bench timeout");
    end
endmodule
